// File: rtl/keyscan_sequencer.sv
// Keyboard matrix scanner: row drive, column debounce, press/release events.
// Define KEYSCAN_REPEAT_EN to add frame-based auto-repeat of held keys.
module keyscan_sequencer #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int ROW_W         = 2,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_clk,
  output logic             div_en,
  output logic [ROWS-1:0]  row_n,
  input  logic [COLS-1:0]  col_n,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [ROW_W+2:0] key_code,
  output logic             key_pressed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] nxt_row;
  logic             div_clk_q;
  logic             tick;
  logic             adv;
  logic             rep_frame;

  logic [COLS-1:0]  stable_q [ROWS];
  logic [2:0]       cnt_q    [ROWS][COLS];
  logic [COLS-1:0]  pend_q;

  logic [COLS-1:0]  samp_stable;
  logic [COLS-1:0]  samp_pend;
  logic [2:0]       samp_cnt [COLS];
  logic [2:0]       samp_lo;
  logic [2:0]       pend_lo;

  function automatic logic [2:0] lowest(input logic [COLS-1:0] v);
    lowest = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  assign tick    = div_clk & ~div_clk_q & div_en;
  assign nxt_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
  assign samp_lo = lowest(samp_pend);
  assign pend_lo = lowest(pend_q);

  // Row is done when its sample found nothing, or its last event drained
  assign adv = (state_q == S_SAMPLE && !(|samp_pend)) ||
               (state_q == S_REPORT && !key_valid && !(|pend_q));

  always_comb begin
    samp_stable = stable_q[row_q];
    samp_pend   = '0;
    for (int c = 0; c < COLS; c++) begin
      samp_cnt[c] = '0;
      if (!col_n[c] != stable_q[row_q][c]) begin
        if (cnt_q[row_q][c] + 3'd1 >= 3'(DEBOUNCE)) begin
          samp_stable[c] = ~stable_q[row_q][c];
          samp_pend[c]   = 1'b1;
        end else begin
          samp_cnt[c] = cnt_q[row_q][c] + 3'd1;
        end
      end
      if (rep_frame && samp_stable[c] && samp_cnt[c] == 3'd0)
        samp_pend[c] = 1'b1;
    end
  end

`ifdef KEYSCAN_REPEAT_EN
  localparam int FC_W = $clog2(REPEAT_FRAMES + 1);

  logic [FC_W-1:0] fc_q;
  logic            rep_q;

  assign rep_frame = rep_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fc_q  <= '0;
      rep_q <= 1'b0;
    end else if (adv && row_q == LAST_ROW) begin
      if (fc_q == FC_W'(REPEAT_FRAMES - 1)) begin
        fc_q  <= '0;
        rep_q <= 1'b1;
      end else begin
        fc_q  <= fc_q + 1'b1;
        rep_q <= 1'b0;
      end
    end
  end
`else
  assign rep_frame = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      div_clk_q   <= 1'b0;
      div_en      <= 1'b0;
      row_n       <= '1;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_pressed <= 1'b0;
      pend_q      <= '0;
      for (int r = 0; r < ROWS; r++) begin
        stable_q[r] <= '0;
        for (int c = 0; c < COLS; c++)
          cnt_q[r][c] <= '0;
      end
    end else begin
      div_clk_q <= div_clk;
      if (adv) begin
        row_q <= nxt_row;
        if (enable) begin
          state_q <= S_DRIVE;
          div_en  <= 1'b1;
          row_n   <= ~(ROWS'(1) << nxt_row);
        end else begin
          state_q <= S_IDLE;
          div_en  <= 1'b0;
          row_n   <= '1;
        end
      end
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_DRIVE;
            div_en  <= 1'b1;
            row_n   <= ~(ROWS'(1) << row_q);
          end
        end
        S_DRIVE, S_SETTLE: begin
          if (!enable) begin
            state_q <= S_IDLE;
            div_en  <= 1'b0;
            row_n   <= '1;
          end else if (tick) begin
            state_q <= (state_q == S_DRIVE) ? S_SETTLE : S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          stable_q[row_q] <= samp_stable;
          pend_q          <= samp_pend;
          for (int c = 0; c < COLS; c++)
            cnt_q[row_q][c] <= samp_cnt[c];
          if (|samp_pend) begin
            state_q     <= S_REPORT;
            div_en      <= 1'b0;
            key_valid   <= 1'b1;
            key_code    <= {row_q, samp_lo};
            key_pressed <= |(samp_stable & (COLS'(1) << samp_lo));
          end
        end
        S_REPORT: begin
          if (key_valid) begin
            if (key_ready) begin
              key_valid <= 1'b0;
              pend_q    <= pend_q & ~(COLS'(1) << key_code[2:0]);
            end
          end else if (|pend_q) begin
            key_valid   <= 1'b1;
            key_code    <= {row_q, pend_lo};
            key_pressed <= |(stable_q[row_q] & (COLS'(1) << pend_lo));
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keyscan_sequencer.sv
// Bench for keyscan_sequencer: keyboard and divider models plus an
// event-level reference model of the debounced key matrix.
module tb_keyscan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       div_clk;
  logic       div_en;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic [4:0] key_code;
  logic       key_pressed;

  logic [1:0] dcnt;
  logic [3:0] mat   [4];
  logic [3:0] mstab [4];
  logic [5:0] exp_q [$];
  logic [5:0] got_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ready_mode = 1;
  bit         hs_prev = 1'b0;

  keyscan_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .div_clk    (div_clk),
    .div_en     (div_en),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Divider: div_clk period of four enabled clk cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dcnt <= '0;
    else if (div_en) dcnt <= dcnt + 2'd1;
  end
  assign div_clk = dcnt[1];

  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~mat[r];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("gap", 32'(key_valid), 32'd0);
      hs_prev = key_valid && key_ready;
      if (hs_prev) got_q.push_back({key_code, key_pressed});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       key_ready = 1'b0;
        1:       key_ready = 1'b1;
        default: key_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Sustained change of a key => exactly one event with its new state
  task automatic note_changes();
    got_q.delete();
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mat[r][c] !== mstab[r][c]) begin
          exp_q.push_back({2'(r), 3'(c), mat[r][c]});
          mstab[r][c] = mat[r][c];
        end
  endtask

  task automatic settle(input int hold, input string tag);
    int idx;
    repeat (hold) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size(); i++) begin
      idx = -1;
      for (int j = 0; j < exp_q.size(); j++)
        if (exp_q[j] === got_q[i]) idx = j;
      check({tag, "_known"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) exp_q.delete(idx);
      if (i > 0 && got_q[i][5:4] == got_q[i-1][5:4])
        check({tag, "_order"}, 32'(got_q[i][3:1] > got_q[i-1][3:1]), 32'd1);
    end
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n = 0;
    while (!key_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_valid), 32'd1);
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin
      mat[r]   = '0;
      mstab[r] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_div_en", 32'(div_en), 32'd0);
    check("rst_row_n", 32'(row_n), 32'hf);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_pressed", 32'(key_pressed), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rel_row_n_idle", 32'(row_n), 32'hf);
    @(negedge clk);
    check("rel_row_n_drive", 32'(row_n), 32'he);
    check("rel_div_en", 32'(div_en), 32'd1);

    @(posedge clk);
    #1 mat[2][1] = 1'b1;
    note_changes();
    settle(600, "press");
    check("press_event", got_q.size() > 0 ? 32'(got_q[0]) : 32'hx, 32'b10_001_1);
    @(posedge clk);
    #1 mat[2][1] = 1'b0;
    note_changes();
    settle(600, "release");
    check("release_event", got_q.size() > 0 ? 32'(got_q[0]) : 32'hx, 32'b10_001_0);

    got_q.delete();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 mat[0][0] = 1'b1;
      repeat (40) @(posedge clk);
      #1 mat[0][0] = 1'b0;
      repeat (80) @(posedge clk);
    end
    @(negedge clk);
    check("bounce_none", got_q.size(), 32'd0);

    ready_mode = 2;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          mat[r][c] = ($urandom_range(0, 3) == 0);
      note_changes();
      settle(800, "rand");
    end

    ready_mode = 1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) mat[r] = '0;
    note_changes();
    settle(600, "clear");

    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    mat[1][0] = 1'b1;
    mat[1][3] = 1'b1;
    note_changes();
    wait_valid(600, "bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(key_valid), 32'd1);
      check("bp_code", 32'(key_code), 32'b01_000);
      check("bp_div_en", 32'(div_en), 32'd0);
    end
    ready_mode = 1;
    settle(300, "bp");
    check("bp_first", got_q.size() > 0 ? 32'(got_q[0]) : 32'hx, 32'b01_000_1);
    check("bp_second", got_q.size() > 1 ? 32'(got_q[1]) : 32'hx, 32'b01_011_1);

    @(posedge clk);
    #1;
    mat[0][2] = 1'b1;
    mat[3][3] = 1'b1;
    note_changes();
    settle(600, "held");
    repeat ($urandom_range(0, 31)) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_row_n", 32'(row_n), 32'hf);
    check("drop_div_en", 32'(div_en), 32'd0);
    repeat (50) @(negedge clk);
    check("parked_row_n", 32'(row_n), 32'hf);
    note_changes();
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (2) @(negedge clk);
    check("resume_onecold", 32'($countones(~row_n)), 32'd1);
    settle(400, "resume");
    @(posedge clk);
    #1 mat[0][2] = 1'b0;
    note_changes();
    settle(600, "after_resume");

    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1 mat[3][3] = 1'b0;
    note_changes();
    wait_valid(600, "mr_valid_timeout");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mr_div_en", 32'(div_en), 32'd0);
    check("mr_row_n", 32'(row_n), 32'hf);
    check("mr_valid", 32'(key_valid), 32'd0);
    check("mr_code", 32'(key_code), 32'd0);
    check("mr_pressed", 32'(key_pressed), 32'd0);
    for (int r = 0; r < 4; r++) mstab[r] = '0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    note_changes();
    @(negedge clk);
    check("mr_rel_idle", 32'(row_n), 32'hf);
    @(negedge clk);
    check("mr_rel_drive", 32'(row_n), 32'he);
    settle(600, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
